// File: rtl/gcm_pkg.sv
// Shared types and helpers for the GCM-AES front-end feeder: widths, FSM state
// encoding, block counting and tail-byte masking.
package gcm_pkg;

    localparam int BLOCK_W   = 128;
    localparam int KEY_W     = 128;
    localparam int IV_W      = 96;
    localparam int LEN_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ISSUE
    } state_t;

    // Number of 16-byte blocks needed to hold a byte count, rounded up.
    function automatic logic [LEN_MAX_W-1:0] blocks_of(input logic [LEN_MAX_W-1:0] bytes);
        return (bytes + LEN_MAX_W'(15)) >> 4;
    endfunction

    // Byte-enable mask for a final partial block; all-ones when the length is a multiple of 16.
    function automatic logic [BLOCK_W-1:0] tail_mask(input logic [3:0] len_lsb);
        logic [BLOCK_W-1:0] m;
        m = '1;
        for (int b = 0; b < BLOCK_W / 8; b++) begin
            if (len_lsb != 4'd0 && b >= int'(len_lsb)) m[8*b +: 8] = 8'h00;
        end
        return m;
    endfunction

endpackage

// File: rtl/gcm_block_buffer.sv
// Single-clock message buffer: incrementing write/read pointers and a registered read
// that looks one block ahead, with write-through when the slot being read is written.
module gcm_block_buffer
    import gcm_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               we,
    input  logic [BLOCK_W-1:0] wr_data,
    input  logic               rd_inc,
    output logic [PTR_W-1:0]   wr_ptr,
    output logic [BLOCK_W-1:0] rd_data
);

    logic [BLOCK_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_addr;

    // Read the slot the pointer will hold after this edge, so rd_data is one block ahead.
    assign rd_addr = rd_ptr + PTR_W'(rd_inc);

    // NOTE: storage has no reset; stale contents are never issued because pointers restart at 0.
    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (we) wr_ptr <= wr_ptr + PTR_W'(1);
                rd_ptr <= rd_addr;
            end
            rd_data <= (we && wr_ptr == rd_addr) ? wr_data : mem[rd_addr];
        end
    end

endmodule

// File: rtl/gcm_aes_feeder.sv
// Buffers one GCM message (header + blocks) and replays it as a gap-free burst to the pipeline.
// Optional build macro GCM_FEEDER_MASK_EN zeroes the unused tail bytes of the last AAD/PT blocks.
module gcm_aes_feeder
    import gcm_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LEN_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_hdr_valid,
    output logic               o_hdr_ready,
    input  logic [KEY_W-1:0]   i_cipher_key,
    input  logic [IV_W-1:0]    i_iv,
    input  logic [LEN_W-1:0]   i_aad_bytes,
    input  logic [LEN_W-1:0]   i_pt_bytes,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [BLOCK_W-1:0] i_data,
    output logic               o_hdr_err,
    output logic               o_busy,
    output logic               o_issue_valid,
    output logic               o_new_instance,
    output logic               o_pt_instance,
    output logic [KEY_W-1:0]   o_cipher_key,
    output logic [IV_W-1:0]    o_iv,
    output logic [BLOCK_W-1:0] o_aad,
    output logic [BLOCK_W-1:0] o_plain_text,
    output logic [63:0]        o_aad_size,
    output logic [63:0]        o_plain_text_size
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, idx;
    logic [CNT_W-1:0]     n_aad_q, total_q, last_idx;
    logic [LEN_MAX_W-1:0] hdr_total;
    logic                 hdr_acc, hdr_ok, beat, last_beat;
    logic                 issue_d, new_d, pt_d, zero_blk, rd_inc;
    logic [PTR_W-1:0]     wr_ptr;
    logic [BLOCK_W-1:0]   rd_data, blk;

    assign hdr_acc   = i_hdr_valid && o_hdr_ready;
    assign beat      = i_valid && o_ready;
    assign hdr_total = blocks_of(LEN_MAX_W'(i_aad_bytes)) + blocks_of(LEN_MAX_W'(i_pt_bytes));
    assign hdr_ok    = hdr_total <= LEN_MAX_W'(DEPTH);
    assign last_beat = CNT_W'(wr_ptr) == total_q - CNT_W'(1);
    assign last_idx  = (total_q == '0) ? '0 : total_q - CNT_W'(1);

    gcm_block_buffer #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q == IDLE),
        .we      (beat),
        .wr_data (i_data),
        .rd_inc  (rd_inc),
        .wr_ptr  (wr_ptr),
        .rd_data (rd_data)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx      = cnt_q;
        issue_d  = 1'b0;
        new_d    = 1'b0;
        zero_blk = 1'b0;
        rd_inc   = 1'b0;
        blk      = rd_data;

        unique case (state_q)
            IDLE: begin
                if (hdr_acc && hdr_ok) begin
                    if (hdr_total == '0) begin
                        state_d  = ISSUE;
                        cnt_d    = '0;
                        issue_d  = 1'b1;
                        new_d    = 1'b1;
                        zero_blk = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (beat && last_beat) begin
                    state_d = ISSUE;
                    cnt_d   = '0;
                    idx     = '0;
                    issue_d = 1'b1;
                    new_d   = 1'b1;
                    rd_inc  = 1'b1;
                    // A one-block message is still being written this edge; take it straight from the input.
                    if (total_q == CNT_W'(1)) blk = i_data;
                end
            end
            ISSUE: begin
                if (cnt_q == last_idx) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    idx     = cnt_q + CNT_W'(1);
                    issue_d = 1'b1;
                    rd_inc  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef GCM_FEEDER_MASK_EN
        if (idx < n_aad_q && idx == n_aad_q - CNT_W'(1))
            blk = blk & tail_mask(o_aad_size[6:3]);
        else if (idx >= n_aad_q && idx == total_q - CNT_W'(1))
            blk = blk & tail_mask(o_plain_text_size[6:3]);
`endif
        if (zero_blk || !issue_d) blk = '0;
        pt_d = issue_d && !zero_blk && (idx >= n_aad_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            n_aad_q           <= '0;
            total_q           <= '0;
            o_hdr_ready       <= 1'b0;
            o_ready           <= 1'b0;
            o_busy            <= 1'b0;
            o_hdr_err         <= 1'b0;
            o_issue_valid     <= 1'b0;
            o_new_instance    <= 1'b0;
            o_pt_instance     <= 1'b0;
            o_aad             <= '0;
            o_plain_text      <= '0;
            o_cipher_key      <= '0;
            o_iv              <= '0;
            o_aad_size        <= '0;
            o_plain_text_size <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            o_hdr_ready    <= (state_d == IDLE);
            o_ready        <= (state_d == LOAD);
            o_busy         <= (state_d != IDLE);
            o_hdr_err      <= hdr_acc && !hdr_ok;
            o_issue_valid  <= issue_d;
            o_new_instance <= new_d;
            o_pt_instance  <= pt_d;
            o_aad          <= pt_d ? '0 : blk;
            o_plain_text   <= pt_d ? blk : '0;
            // Rejected headers leave the previous message's key, IV and sizes untouched.
            if (hdr_acc && hdr_ok) begin
                n_aad_q           <= CNT_W'(blocks_of(LEN_MAX_W'(i_aad_bytes)));
                total_q           <= CNT_W'(hdr_total);
                o_cipher_key      <= i_cipher_key;
                o_iv              <= i_iv;
                o_aad_size        <= {{(64-LEN_W-3){1'b0}}, i_aad_bytes, 3'b000};
                o_plain_text_size <= {{(64-LEN_W-3){1'b0}}, i_pt_bytes, 3'b000};
            end
        end
    end

endmodule
